// File: rtl/hid_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hid_pkg
// Brief    : Shared types and constants for the HID keyboard event block.
// Revision : 1.0 - initial release
// ============================================================================
package hid_pkg;

  localparam logic [1:0] HID_TYP_NONE  = 2'd0;
  localparam logic [1:0] HID_TYP_KBD   = 2'd1;
  localparam logic [1:0] HID_TYP_MOUSE = 2'd2;
  localparam logic [1:0] HID_TYP_GAME  = 2'd3;

  localparam logic [7:0] HID_ROLLOVER = 8'h01;
  localparam logic [7:0] HID_MOD_BASE = 8'hE0;

  typedef struct packed {
    logic       rpt;
    logic       make;
    logic [7:0] code;
    logic [7:0] mods;
  } hid_event_t;

  typedef struct packed {
    logic [7:0]      mods;
    logic [3:0][7:0] keys;
  } hid_report_t;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_BRK    = 3'd1,
    S_MK     = 3'd2,
    S_MOD    = 3'd3,
    S_COMMIT = 3'd4
  } hid_scan_state_t;

  function automatic logic hid_key_in(input logic [7:0] code, input logic [3:0][7:0] keys);
    hid_key_in = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (keys[i] == code) hid_key_in = 1'b1;
    end
  endfunction

endpackage
`default_nettype wire

// File: rtl/hid_event_fifo.sv
`default_nettype none
// ============================================================================
// Module   : hid_event_fifo
// Brief    : First-word-fall-through event FIFO with drop-on-full and a
//            sticky overflow flag.
// Revision : 1.0 - initial release
// ============================================================================
module hid_event_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 18
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_ready,
  input  logic             i_clear_ovf,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data,
  output logic             o_overflow
);

  localparam int          AW     = $clog2(DEPTH);
  localparam logic [AW:0] c_full = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             r_ovf;

  logic w_pop;
  logic w_full;
  logic w_wr;
  logic w_drop;

  assign w_pop  = (r_count != '0) && i_ready;
  assign w_full = (r_count == c_full);
  // A pop in the same cycle frees the slot, so a push into a full FIFO is kept.
  assign w_wr   = i_push && (!w_full || w_pop);
  assign w_drop = i_push && w_full && !w_pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_wr)  r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_wr && !w_pop)      r_count <= r_count + 1'b1;
      else if (!w_wr && w_pop) r_count <= r_count - 1'b1;
      if (w_drop)           r_ovf <= 1'b1;
      else if (i_clear_ovf) r_ovf <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= i_data;
  end

  assign o_valid    = (r_count != '0);
  assign o_data     = o_valid ? r_mem[r_rd_ptr] : '0;
  assign o_overflow = r_ovf;

endmodule
`default_nettype wire

// File: rtl/hid_key_events.sv
`default_nettype none
// ============================================================================
// Module   : hid_key_events
// Brief    : Diffs successive HID keyboard reports into make/break events.
// Config   : HID_KEY_EVENTS_REPEAT_EN enables the auto-repeat timer.
// Revision : 1.0 - initial release
// ============================================================================
module hid_key_events
  import hid_pkg::*;
#(
  parameter int DEPTH        = 16,
  parameter int REPEAT_DELAY = 6000000,
  parameter int REPEAT_RATE  = 400000
) (
  input  logic       usbclk,
  input  logic       usbrst_n,
  input  logic       report,
  input  logic [1:0] typ,
  input  logic       conerr,
  input  logic [7:0] key_modifiers,
  input  logic [7:0] key1,
  input  logic [7:0] key2,
  input  logic [7:0] key3,
  input  logic [7:0] key4,
  output logic       ev_valid,
  input  logic       ev_ready,
  output logic [7:0] ev_code,
  output logic       ev_make,
  output logic [7:0] ev_mods,
  output logic       ev_repeat,
  output logic       overflow,
  input  logic       clear_ovf
);

  hid_scan_state_t r_state, w_state_nxt;
  logic [2:0]      r_idx, w_idx_nxt;
  hid_report_t     r_cur, r_prev, r_pend;
  logic            r_pend_vld, r_pend_rel, r_conerr_d;

  hid_report_t w_in, w_start_rpt;
  logic        w_rollover, w_take, w_rel, w_arr, w_start, w_start_rel;
  logic [7:0]  w_k_prev, w_k_cur;
  logic        w_dup, w_scan_push, w_rep_push, w_fifo_push;
  hid_event_t  w_scan_ev, w_rep_ev, w_fifo_ev, w_head;

  assign w_in.mods  = key_modifiers;
  assign w_in.keys  = {key4, key3, key2, key1};
  assign w_rollover = (key1 == HID_ROLLOVER) || (key2 == HID_ROLLOVER) ||
                      (key3 == HID_ROLLOVER) || (key4 == HID_ROLLOVER);
  assign w_take     = report && (typ == HID_TYP_KBD) && !w_rollover;
  assign w_rel      = conerr && !r_conerr_d;
  assign w_arr      = w_take || w_rel;

  // A fresh arrival is newer than anything pending; release-all wins a tie.
  assign w_start     = w_arr || r_pend_vld;
  assign w_start_rel = w_arr ? w_rel : r_pend_rel;
  assign w_start_rpt = w_arr ? w_in  : r_pend;

  always_ff @(posedge usbclk or negedge usbrst_n) begin
    if (!usbrst_n) begin
      r_state    <= S_IDLE;
      r_idx      <= '0;
      r_cur      <= '0;
      r_prev     <= '0;
      r_pend     <= '0;
      r_pend_vld <= 1'b0;
      r_pend_rel <= 1'b0;
      r_conerr_d <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_idx      <= w_idx_nxt;
      r_conerr_d <= conerr;
      if (r_state == S_IDLE) begin
        if (w_start) begin
          r_cur      <= w_start_rel ? '0 : w_start_rpt;
          r_pend_vld <= 1'b0;
        end
      end else if (w_arr) begin
        r_pend_vld <= 1'b1;
        r_pend_rel <= w_rel;
        r_pend     <= w_in;
      end
      if (r_state == S_COMMIT) r_prev <= r_cur;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_idx_nxt      = r_idx;
    w_scan_push    = 1'b0;
    w_scan_ev      = '0;
    w_scan_ev.mods = r_cur.mods;
    w_k_prev       = r_prev.keys[r_idx[1:0]];
    w_k_cur        = r_cur.keys[r_idx[1:0]];
    w_dup          = 1'b0;
    for (int j = 0; j < 4; j++) begin
      if ((3'(j) < r_idx) && (r_cur.keys[j] == w_k_cur)) w_dup = 1'b1;
    end

    unique case (r_state)
      S_IDLE: begin
        if (w_start) begin
          w_state_nxt = S_BRK;
          w_idx_nxt   = '0;
        end
      end
      S_BRK: begin
        if ((w_k_prev != 8'h00) && !hid_key_in(w_k_prev, r_cur.keys)) begin
          w_scan_push    = 1'b1;
          w_scan_ev.code = w_k_prev;
          w_scan_ev.make = 1'b0;
        end
        if (r_idx == 3'd3) begin
          w_state_nxt = S_MK;
          w_idx_nxt   = '0;
        end else begin
          w_idx_nxt = r_idx + 3'd1;
        end
      end
      S_MK: begin
        if ((w_k_cur != 8'h00) && !hid_key_in(w_k_cur, r_prev.keys) && !w_dup) begin
          w_scan_push    = 1'b1;
          w_scan_ev.code = w_k_cur;
          w_scan_ev.make = 1'b1;
        end
        if (r_idx == 3'd3) begin
          w_state_nxt = S_MOD;
          w_idx_nxt   = '0;
        end else begin
          w_idx_nxt = r_idx + 3'd1;
        end
      end
      S_MOD: begin
        if (r_prev.mods[r_idx] != r_cur.mods[r_idx]) begin
          w_scan_push    = 1'b1;
          w_scan_ev.code = HID_MOD_BASE + {5'd0, r_idx};
          w_scan_ev.make = r_cur.mods[r_idx];
        end
        if (r_idx == 3'd7) w_state_nxt = S_COMMIT;
        else               w_idx_nxt   = r_idx + 3'd1;
      end
      S_COMMIT: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

`ifdef HID_KEY_EVENTS_REPEAT_EN
  localparam logic [31:0] c_rep_delay = 32'(REPEAT_DELAY - 1);
  localparam logic [31:0] c_rep_rate  = 32'(REPEAT_RATE - 1);

  logic        r_rep_act, r_rep_pend;
  logic [7:0]  r_rep_key;
  logic [31:0] r_rep_cnt;
  logic        w_rep_due, w_rep_arm, w_rep_cancel, w_rel_start;

  assign w_rel_start  = (r_state == S_IDLE) && w_start && w_start_rel;
  assign w_rep_due    = r_rep_act && (r_rep_cnt == '0);
  // A repeat falling due mid-scan waits here until the scan returns to IDLE.
  assign w_rep_push   = (r_rep_pend || w_rep_due) && (r_state == S_IDLE) && !w_rel_start;
  assign w_rep_arm    = w_scan_push && (r_state == S_MK);
  assign w_rep_cancel = w_rel_start ||
                        (w_scan_push && (r_state == S_BRK) && (w_scan_ev.code == r_rep_key));
  assign w_rep_ev     = {1'b1, 1'b1, r_rep_key, r_prev.mods};

  always_ff @(posedge usbclk or negedge usbrst_n) begin
    if (!usbrst_n) begin
      r_rep_act  <= 1'b0;
      r_rep_pend <= 1'b0;
      r_rep_key  <= '0;
      r_rep_cnt  <= '0;
    end else if (w_rep_cancel) begin
      r_rep_act  <= 1'b0;
      r_rep_pend <= 1'b0;
    end else if (w_rep_arm) begin
      r_rep_act  <= 1'b1;
      r_rep_pend <= 1'b0;
      r_rep_key  <= w_scan_ev.code;
      r_rep_cnt  <= c_rep_delay;
    end else begin
      if (w_rep_due)      r_rep_cnt <= c_rep_rate;
      else if (r_rep_act) r_rep_cnt <= r_rep_cnt - 32'd1;
      r_rep_pend <= (r_rep_pend || w_rep_due) && !w_rep_push;
    end
  end
`else
  logic w_unused_rep;

  assign w_rep_push   = 1'b0;
  assign w_rep_ev     = '0;
  assign w_unused_rep = ^{REPEAT_DELAY[0], REPEAT_RATE[0]};
`endif

  assign w_fifo_push = w_scan_push || w_rep_push;
  assign w_fifo_ev   = w_rep_push ? w_rep_ev : w_scan_ev;

  hid_event_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(hid_event_t))
  ) u_fifo (
    .clk         (usbclk),
    .rst_n       (usbrst_n),
    .i_push      (w_fifo_push),
    .i_data      (w_fifo_ev),
    .i_ready     (ev_ready),
    .i_clear_ovf (clear_ovf),
    .o_valid     (ev_valid),
    .o_data      (w_head),
    .o_overflow  (overflow)
  );

  assign ev_code   = w_head.code;
  assign ev_make   = w_head.make;
  assign ev_mods   = w_head.mods;
  assign ev_repeat = w_head.rpt;

endmodule
`default_nettype wire

// File: tb/tb_hid_key_events.sv
`default_nettype none
// ============================================================================
// Module   : tb_hid_key_events
// Brief    : Self-checking bench for hid_key_events against a list-based
//            report-diff model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hid_key_events;

  logic       usbclk = 1'b0;
  logic       usbrst_n = 1'b0;
  logic       report = 1'b0;
  logic [1:0] typ = 2'd0;
  logic       conerr = 1'b0;
  logic [7:0] key_modifiers = 8'h00;
  logic [7:0] key1 = 8'h00, key2 = 8'h00, key3 = 8'h00, key4 = 8'h00;
  logic       ev_ready = 1'b0;
  logic       clear_ovf = 1'b0;
  logic       ev_valid, ev_make, ev_repeat, overflow;
  logic [7:0] ev_code, ev_mods;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  int t_seen = 0;

  logic [7:0]  m_mods = 8'h00;
  logic [31:0] m_keys = 32'h0;
  logic [17:0] exp_q[$];

  hid_key_events #(
    .DEPTH        (16),
    .REPEAT_DELAY (20),
    .REPEAT_RATE  (5)
  ) dut (
    .usbclk        (usbclk),
    .usbrst_n      (usbrst_n),
    .report        (report),
    .typ           (typ),
    .conerr        (conerr),
    .key_modifiers (key_modifiers),
    .key1          (key1),
    .key2          (key2),
    .key3          (key3),
    .key4          (key4),
    .ev_valid      (ev_valid),
    .ev_ready      (ev_ready),
    .ev_code       (ev_code),
    .ev_make       (ev_make),
    .ev_mods       (ev_mods),
    .ev_repeat     (ev_repeat),
    .overflow      (overflow),
    .clear_ovf     (clear_ovf)
  );

  always #5 usbclk = ~usbclk;
  always @(posedge usbclk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    assert (got === want) else begin
      n_err++;
      $error("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  function automatic bit has_key(input logic [31:0] ks, input logic [7:0] k, input int n);
    has_key = 1'b0;
    for (int i = 0; i < n; i++) if (ks[8*i +: 8] == k) has_key = 1'b1;
  endfunction

  // Expected events of one accepted report: breaks, makes, then modifier edges.
  task automatic model_report(input logic [7:0] cm, input logic [31:0] ck);
    logic [7:0] k;
    for (int i = 0; i < 4; i++) begin
      k = m_keys[8*i +: 8];
      if (k != 8'h00 && !has_key(ck, k, 4)) exp_q.push_back({1'b0, 1'b0, k, cm});
    end
    for (int i = 0; i < 4; i++) begin
      k = ck[8*i +: 8];
      if (k != 8'h00 && !has_key(m_keys, k, 4) && !has_key(ck, k, i))
        exp_q.push_back({1'b0, 1'b1, k, cm});
    end
    for (int b = 0; b < 8; b++) begin
      if (m_mods[b] != cm[b]) exp_q.push_back({1'b0, cm[b], 8'hE0 + 8'(b), cm});
    end
    m_mods = cm;
    m_keys = ck;
  endtask

  task automatic send_report(input logic [7:0] m, input logic [31:0] k, input logic [1:0] t);
    typ = t;
    key_modifiers = m;
    {key4, key3, key2, key1} = k;
    report = 1'b1;
    @(posedge usbclk);
    #1 report = 1'b0;
  endtask

  task automatic pulse_conerr();
    conerr = 1'b1;
    @(posedge usbclk);
    #1 conerr = 1'b0;
  endtask

  task automatic expect_event(input string tag, input logic [17:0] want);
    int n;
    n = 0;
    @(negedge usbclk);
    while (ev_valid !== 1'b1 && n < 64) begin
      @(negedge usbclk);
      n++;
    end
    check({tag, "_valid"}, {31'd0, ev_valid}, 32'd1);
    if (ev_valid === 1'b1) begin
      t_seen = cyc;
      check(tag, {14'd0, ev_repeat, ev_make, ev_code, ev_mods}, {14'd0, want});
      ev_ready = 1'b1;
      @(posedge usbclk);
      #1 ev_ready = 1'b0;
    end
  endtask

  task automatic drain(input string tag);
    while (exp_q.size() > 0) expect_event(tag, exp_q.pop_front());
  endtask

  task automatic expect_quiet(input string tag, input int n);
    repeat (n) @(negedge usbclk);
    check(tag, {31'd0, ev_valid}, 32'd0);
  endtask

  initial begin
    logic [31:0] rk;
    logic [7:0]  rm;
    int          kind;
    int          t_make;
    int          t_r1;

    repeat (3) @(negedge usbclk);
    check("rst_valid",  {31'd0, ev_valid},  32'd0);
    check("rst_code",   {24'd0, ev_code},   32'd0);
    check("rst_make",   {31'd0, ev_make},   32'd0);
    check("rst_mods",   {24'd0, ev_mods},   32'd0);
    check("rst_repeat", {31'd0, ev_repeat}, 32'd0);
    check("rst_ovf",    {31'd0, overflow},  32'd0);
    usbrst_n = 1'b1;
    @(negedge usbclk);

`ifndef HID_KEY_EVENTS_REPEAT_EN
    // Press: the make comes from MK0, visible the cycle after it.
    send_report(8'h00, 32'h0000_0004, 2'd1);
    model_report(8'h00, 32'h0000_0004);
    repeat (5) begin
      @(negedge usbclk);
      check("press_early", {31'd0, ev_valid}, 32'd0);
    end
    @(negedge usbclk);
    check("press_first", {31'd0, ev_valid}, 32'd1);
    drain("press");
    expect_quiet("press_quiet", 25);

    // Break then modifier make; a break at BRK0 is visible at N+2.
    send_report(8'h02, 32'h0, 2'd1);
    model_report(8'h02, 32'h0);
    @(negedge usbclk);
    check("brk_n1", {31'd0, ev_valid}, 32'd0);
    @(negedge usbclk);
    check("brk_n2", {31'd0, ev_valid}, 32'd1);
    drain("brkmk");
    expect_quiet("brkmk_quiet", 25);

    // Rollover reports leave the snapshot untouched.
    send_report(8'h00, 32'h0000_0004, 2'd1);
    model_report(8'h00, 32'h0000_0004);
    drain("repress");
    expect_quiet("repress_quiet", 25);
    send_report(8'h00, 32'h0101_0101, 2'd1);
    expect_quiet("rollover_quiet", 25);
    send_report(8'h00, 32'h0000_0005, 2'd1);
    model_report(8'h00, 32'h0000_0005);
    drain("after_roll");
    expect_quiet("after_roll_quiet", 25);

    // Overflow: 24 events into a 16-deep FIFO with the consumer stalled.
    send_report(8'h00, 32'h0, 2'd1);
    model_report(8'h00, 32'h0);
    drain("clear");
    expect_quiet("clear_quiet", 25);
    send_report(8'hFF, 32'h0706_0504, 2'd1);
    model_report(8'hFF, 32'h0706_0504);
    repeat (20) @(negedge usbclk);
    check("ovf_12", {31'd0, overflow}, 32'd0);
    send_report(8'h00, 32'h0, 2'd1);
    model_report(8'h00, 32'h0);
    repeat (22) @(negedge usbclk);
    check("ovf_set", {31'd0, overflow}, 32'd1);
    while (exp_q.size() > 16) void'(exp_q.pop_back());
    clear_ovf = 1'b1;
    @(posedge usbclk);
    #1 clear_ovf = 1'b0;
    @(negedge usbclk);
    check("ovf_clr", {31'd0, overflow}, 32'd0);
    drain("ovf_keep");
    expect_quiet("ovf_quiet", 25);

    // Unplug with a report arriving mid-scan.
    send_report(8'h00, 32'h0000_0504, 2'd1);
    model_report(8'h00, 32'h0000_0504);
    drain("hold2");
    expect_quiet("hold2_quiet", 25);
    pulse_conerr();
    @(posedge usbclk);
    #1 send_report(8'h00, 32'h0000_0006, 2'd1);
    model_report(8'h00, 32'h0);
    model_report(8'h00, 32'h0000_0006);
    drain("unplug");
    expect_quiet("unplug_quiet", 30);

    // Reset mid-scan clears the snapshot; the next report diffs against zero.
    send_report(8'h00, 32'h0000_0008, 2'd1);
    repeat (3) @(negedge usbclk);
    usbrst_n = 1'b0;
    @(negedge usbclk);
    check("midrst_valid", {31'd0, ev_valid}, 32'd0);
    usbrst_n = 1'b1;
    m_mods = 8'h00;
    m_keys = 32'h0;
    exp_q.delete();
    expect_quiet("midrst_quiet", 25);
    send_report(8'h00, 32'h0000_0009, 2'd1);
    model_report(8'h00, 32'h0000_0009);
    drain("midrst_next");
    expect_quiet("midrst_next_quiet", 25);

    // Randomised reports, ignored reports and unplugs.
    for (int it = 0; it < 40; it++) begin
      kind = int'($urandom_range(0, 9));
      rm = 8'($urandom);
      for (int s = 0; s < 4; s++)
        rk[8*s +: 8] = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'(8'h04 + $urandom_range(0, 5));
      if (kind == 0) begin
        rk[8*$urandom_range(0, 3) +: 8] = 8'h01;
        send_report(rm, rk, 2'd1);
      end else if (kind == 1) begin
        send_report(rm, rk, ($urandom_range(0, 1) == 0) ? 2'd0 : 2'd2 + 2'($urandom_range(0, 1)));
      end else if (kind == 2) begin
        pulse_conerr();
        model_report(8'h00, 32'h0);
      end else begin
        send_report(rm, rk, 2'd1);
        model_report(rm, rk);
      end
      repeat (20) @(negedge usbclk);
      drain("rand");
      expect_quiet("rand_quiet", 3);
    end
`else
    // Auto-repeat: make, then repeats 20 and 25 cycles after it.
    send_report(8'h00, 32'h0000_0004, 2'd1);
    model_report(8'h00, 32'h0000_0004);
    drain("rep_make");
    t_make = t_seen;
    expect_event("rep_first", {1'b1, 1'b1, 8'h04, 8'h00});
    t_r1 = t_seen;
    check("rep_first_dly", 32'(t_r1 - t_make), 32'd20);
    expect_event("rep_second", {1'b1, 1'b1, 8'h04, 8'h00});
    check("rep_second_dly", 32'(t_seen - t_make), 32'd25);
    send_report(8'h00, 32'h0, 2'd1);
    model_report(8'h00, 32'h0);
    drain("rep_release");
    expect_quiet("rep_stopped", 60);
    check("rep_ovf", {31'd0, overflow}, 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
